// File: rtl/uart_cmd_parser.sv
// Command-frame parser behind the UART receiver: A5, ADDR, D3..D0, CHK -> one register write.
// Optional `UART_CMD_ACK_EN adds an ACK/NAK byte strobe for a UART transmitter.
module uart_cmd_parser #(
  parameter int TIMEOUT_CLKS = 125000,
  parameter int N_REGS       = 4
) (
  input  logic        i_Clock,
  input  logic        i_Rst_L,
  input  logic        i_RX_DV,
  input  logic [7:0]  i_RX_Byte,
  output logic        o_Reg_WE,
  output logic [7:0]  o_Reg_Addr,
  output logic [31:0] o_Reg_Data,
  output logic        o_Frame_Err,
  output logic        o_Busy
`ifdef UART_CMD_ACK_EN
  ,
  output logic        o_Ack_DV,
  output logic [7:0]  o_Ack_Byte
`endif
);

  // state | meaning
  // SYNC  | idle, hunting for the 0xA5 header; other bytes dropped silently
  // ADDR  | next byte is the register address
  // DATA  | collecting D3..D0, MSB first
  // CHK   | next byte is the XOR checksum; decides write vs error

  localparam int             CW   = $clog2(TIMEOUT_CLKS);
  localparam logic [CW-1:0]  TC   = CW'(TIMEOUT_CLKS - 1);
  localparam logic [CW-1:0]  CMAX = '1;
  localparam logic [8:0]     NR   = 9'(N_REGS);
  localparam logic [7:0]     HDR  = 8'hA5;

  typedef enum logic [1:0] {SYNC, ADDR, DATA, CHK} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] tmo_cnt;
  logic [1:0]    dcnt;
  logic [7:0]    addr_q;
  logic [7:0]    xor_q;
  logic [31:0]   shift_q;
  logic          timeout;
  logic          chk_ok;
  logic          we_nxt;
  logic          err_nxt;

  // A byte arriving on the timeout cycle takes priority over the timeout.
  assign timeout = (state != SYNC) && !i_RX_DV && (tmo_cnt == TC);
  assign chk_ok  = (i_RX_Byte == xor_q) && ({1'b0, addr_q} < NR);

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) state <= SYNC;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = SYNC;
    end else if (i_RX_DV) begin
      case (state)
        SYNC: if (i_RX_Byte == HDR) state_nxt = ADDR;
        ADDR: state_nxt = DATA;
        DATA: if (dcnt == 2'd3) state_nxt = CHK;
        CHK:  state_nxt = SYNC;
        default: state_nxt = SYNC;
      endcase
    end
  end

  always_comb begin
    we_nxt  = 1'b0;
    err_nxt = 1'b0;
    if (timeout) begin
      err_nxt = 1'b1;
    end else if (i_RX_DV && state == CHK) begin
      we_nxt  = chk_ok;
      err_nxt = !chk_ok;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Reg_WE    <= 1'b0;
      o_Frame_Err <= 1'b0;
      o_Busy      <= 1'b0;
      o_Reg_Addr  <= '0;
      o_Reg_Data  <= '0;
      tmo_cnt     <= '0;
      dcnt        <= '0;
      addr_q      <= '0;
      xor_q       <= '0;
      shift_q     <= '0;
    end else begin
      o_Reg_WE    <= we_nxt;
      o_Frame_Err <= err_nxt;
      o_Busy      <= (state_nxt != SYNC);
      if (we_nxt) begin
        o_Reg_Addr <= addr_q;
        o_Reg_Data <= shift_q;
      end

      if (i_RX_DV || state_nxt == SYNC) tmo_cnt <= '0;
      else if (tmo_cnt != CMAX)         tmo_cnt <= tmo_cnt + 1'b1;

      if (i_RX_DV) begin
        case (state)
          SYNC: if (i_RX_Byte == HDR) xor_q <= '0;
          ADDR: begin
            addr_q <= i_RX_Byte;
            xor_q  <= xor_q ^ i_RX_Byte;
            dcnt   <= '0;
          end
          DATA: begin
            shift_q <= {shift_q[23:0], i_RX_Byte};
            xor_q   <= xor_q ^ i_RX_Byte;
            dcnt    <= dcnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef UART_CMD_ACK_EN
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Ack_DV   <= 1'b0;
      o_Ack_Byte <= '0;
    end else begin
      o_Ack_DV <= we_nxt | err_nxt;
      if (we_nxt)       o_Ack_Byte <= 8'h06;
      else if (err_nxt) o_Ack_Byte <= 8'h15;
    end
  end
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: frame-level model compared every cycle,
// plus literal checks on write counts, address and data.
module tb_uart_cmd_parser;
  localparam int TO = 16;
  localparam int NR = 4;

  logic        i_Clock = 1'b0;
  logic        i_Rst_L = 1'b1;
  logic        i_RX_DV = 1'b0;
  logic [7:0]  i_RX_Byte = 8'h00;
  logic        o_Reg_WE;
  logic [7:0]  o_Reg_Addr;
  logic [31:0] o_Reg_Data;
  logic        o_Frame_Err;
  logic        o_Busy;
`ifdef UART_CMD_ACK_EN
  logic        o_Ack_DV;
  logic [7:0]  o_Ack_Byte;
`endif

  uart_cmd_parser #(.TIMEOUT_CLKS(TO), .N_REGS(NR)) dut (
    .i_Clock    (i_Clock),
    .i_Rst_L    (i_Rst_L),
    .i_RX_DV    (i_RX_DV),
    .i_RX_Byte  (i_RX_Byte),
    .o_Reg_WE   (o_Reg_WE),
    .o_Reg_Addr (o_Reg_Addr),
    .o_Reg_Data (o_Reg_Data),
    .o_Frame_Err(o_Frame_Err),
    .o_Busy     (o_Busy)
`ifdef UART_CMD_ACK_EN
    ,
    .o_Ack_DV   (o_Ack_DV),
    .o_Ack_Byte (o_Ack_Byte)
`endif
  );

  always #5 i_Clock = ~i_Clock;

  int tests = 0;
  int fails = 0;
  int we_cnt = 0;
  int err_cnt = 0;

  // model state: open frame flag, bytes after the header, idle clocks since last byte
  bit          m_open = 0;
  int          m_idle = 0;
  logic [7:0]  fq[$];
  logic [7:0]  m_x;
  logic        e_we = 0, e_err = 0, e_busy = 0;
  logic [7:0]  e_addr = 0;
  logic [31:0] e_data = 0;
  logic        e_ack_dv = 0;
  logic [7:0]  e_ack_byte = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge i_Clock or negedge i_Rst_L);
    if (!i_Rst_L) begin
      m_open = 0; m_idle = 0; fq.delete();
      e_we = 0; e_err = 0; e_busy = 0; e_addr = 0; e_data = 0;
      e_ack_dv = 0; e_ack_byte = 0;
    end else begin
      e_we = 0; e_err = 0;
      if (i_RX_DV) begin
        m_idle = 0;
        if (!m_open) begin
          if (i_RX_Byte == 8'hA5) begin m_open = 1; fq.delete(); end
        end else begin
          fq.push_back(i_RX_Byte);
          if (fq.size() == 6) begin
            m_x = fq[0] ^ fq[1] ^ fq[2] ^ fq[3] ^ fq[4];
            if (m_x == fq[5] && int'(fq[0]) < NR) begin
              e_we = 1; e_addr = fq[0]; e_data = {fq[1], fq[2], fq[3], fq[4]};
            end else begin
              e_err = 1;
            end
            m_open = 0;
          end
        end
      end else if (m_open) begin
        m_idle++;
        if (m_idle == TO) begin e_err = 1; m_open = 0; end
      end
      e_busy = m_open;
      e_ack_dv = e_we | e_err;
      if (e_we) e_ack_byte = 8'h06;
      else if (e_err) e_ack_byte = 8'h15;
    end
  end

  initial forever begin
    @(negedge i_Clock);
    check("we", o_Reg_WE, e_we);
    check("err", o_Frame_Err, e_err);
    check("busy", o_Busy, e_busy);
    check("addr", o_Reg_Addr, e_addr);
    check("data", o_Reg_Data, e_data);
`ifdef UART_CMD_ACK_EN
    check("ack_dv", o_Ack_DV, e_ack_dv);
    check("ack_byte", o_Ack_Byte, e_ack_byte);
`endif
    if (o_Reg_WE) we_cnt++;
    if (o_Frame_Err) err_cnt++;
  end

  task automatic send(input logic [7:0] b);
    @(negedge i_Clock);
    i_RX_DV = 1'b1;
    i_RX_Byte = b;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_Clock);
      i_RX_DV = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input logic [7:0] c);
    send(8'hA5); send(a);
    send(d[31:24]); send(d[23:16]); send(d[15:8]); send(d[7:0]);
    send(c);
  endtask

  task automatic pin(input string name, input int w, input int e);
    idle_n(3);
    #1;
    check({name, "_we_cnt"}, w, 32'(we_cnt) == 32'(w) ? w : we_cnt);
    check({name, "_err_cnt"}, err_cnt, e);
  endtask

  initial begin
    #1 i_Rst_L = 1'b0;
    repeat (3) @(negedge i_Clock);
    #2 i_Rst_L = 1'b1;
    #1;
    check("rst_busy", o_Busy, 0);
    check("rst_we", o_Reg_WE, 0);
    check("rst_err", o_Frame_Err, 0);
    check("rst_addr", o_Reg_Addr, 0);
    check("rst_data", o_Reg_Data, 0);

    send_frame(8'h01, 32'h12345678, 8'h09);
    idle_n(3); #1;
    check("f1_we_cnt", we_cnt, 1);
    check("f1_err_cnt", err_cnt, 0);
    check("f1_addr", o_Reg_Addr, 32'h01);
    check("f1_data", o_Reg_Data, 32'h12345678);

    send_frame(8'h01, 32'h12345678, 8'h08);
    idle_n(3); #1;
    check("badchk_we_cnt", we_cnt, 1);
    check("badchk_err_cnt", err_cnt, 1);

    send_frame(8'h04, 32'h12345678, 8'h0C);
    idle_n(3); #1;
    check("badaddr_we_cnt", we_cnt, 1);
    check("badaddr_err_cnt", err_cnt, 2);

    send(8'hA5); send(8'h02); send(8'hAA);
    idle_n(TO + 4); #1;
    check("tmo_err_cnt", err_cnt, 3);
    check("tmo_busy", o_Busy, 0);
    send_frame(8'h03, 32'hDEADBEEF, 8'h21);
    idle_n(3); #1;
    check("after_tmo_we_cnt", we_cnt, 2);
    check("after_tmo_data", o_Reg_Data, 32'hDEADBEEF);

    send(8'h00); send(8'hFF); send(8'h5A);
    send_frame(8'h01, 32'h12345678, 8'h09);
    send_frame(8'h00, 32'hA5A5A5A5, 8'h00);
    idle_n(3); #1;
    check("garbage_we_cnt", we_cnt, 4);
    check("garbage_err_cnt", err_cnt, 3);
    check("a5_addr", o_Reg_Addr, 32'h00);
    check("a5_data", o_Reg_Data, 32'hA5A5A5A5);

    // byte on the last idle clock beats the timeout
    send(8'hA5); send(8'h02);
    idle_n(TO - 1);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h46);
    idle_n(3); #1;
    check("race_we_cnt", we_cnt, 5);
    check("race_err_cnt", err_cnt, 3);

    send(8'hA5);
    idle_n(TO);
    send(8'h00);
    idle_n(3); #1;
    check("tmo_exact_err_cnt", err_cnt, 4);

    send_frame(8'h00, 32'h01020304, 8'h04);
    send_frame(8'h01, 32'h01020304, 8'h05);
    idle_n(3); #1;
    check("b2b_we_cnt", we_cnt, 7);
    check("b2b_addr", o_Reg_Addr, 32'h01);

    send(8'hA5); send(8'h02); send(8'h12); send(8'h34);
    @(negedge i_Clock); i_RX_DV = 1'b0;
    #2 i_Rst_L = 1'b0;
    #1;
    check("mid_rst_busy", o_Busy, 0);
    check("mid_rst_addr", o_Reg_Addr, 0);
    check("mid_rst_data", o_Reg_Data, 0);
    @(negedge i_Clock);
    #2 i_Rst_L = 1'b1;
    idle_n(TO + 4); #1;
    check("mid_rst_we_cnt", we_cnt, 7);
    check("mid_rst_err_cnt", err_cnt, 4);
    send_frame(8'h01, 32'h12345678, 8'h09);
    idle_n(3); #1;
    check("post_rst_we_cnt", we_cnt, 8);
    check("post_rst_data", o_Reg_Data, 32'h12345678);

    idle_n(2); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Frame parser and register-write sequencer that sits directly behind the UART receiver in the frequency counter. It consumes the receiver's byte/valid stream, assembles fixed-length command frames, validates them, and issues single-cycle register writes that configure the counter datapath (gate time, prescaler, mode, etc.). Malformed, out-of-range, or stalled frames are discarded and flagged.

## Interface
- `TIMEOUT_CLKS`, 125000: inter-byte timeout in clocks while a frame is open; minimum 2.
- `N_REGS`, 4: number of writable registers; valid addresses are 0..N_REGS-1; range 1..256.
- `i_Clock` in 1: system clock; all logic on rising edge.
- `i_Rst_L` in 1: reset; asynchronous, active-low.
- `i_RX_DV` in 1: byte-valid strobe from the UART receiver; one-cycle pulse.
- `i_RX_Byte` in 8: received byte; sampled only when `i_RX_DV`=1.
- `o_Reg_WE` out 1: register write strobe; one-cycle pulse.
- `o_Reg_Addr` out 8: write address; valid while `o_Reg_WE`=1, held otherwise.
- `o_Reg_Data` out 32: write data; valid while `o_Reg_WE`=1, held otherwise.
- `o_Frame_Err` out 1: one-cycle pulse on any discarded frame.
- `o_Busy` out 1: high while a frame is open (any state other than SYNC).

## Operation
- Frame, 7 bytes: `0xA5`, ADDR, D3, D2, D1, D0 (data MSB first), CHK.
- CHK = XOR of ADDR, D3, D2, D1, D0.
- States:
  - SYNC: wait for a byte. `0xA5` -> ADDR. Any other byte is dropped silently with no error.
  - ADDR: capture the byte -> DATA and clear the data-byte counter.
  - DATA: shift the byte into a 32-bit shift register MSB first. After the 4th byte -> CHK.
  - CHK: compare against the running XOR, then return to SYNC. A match with ADDR < N_REGS gives a write. A mismatch, or ADDR >= N_REGS, gives `o_Frame_Err` and no write.
- Running XOR clears on entry to ADDR and accumulates ADDR..D0.
- `0xA5` received in ADDR/DATA/CHK is ordinary payload. There is no mid-frame resync.
- Timeout:
  - A counter clears on every accepted byte and on entry to SYNC.
  - It increments each cycle while not in SYNC.
  - On reaching TIMEOUT_CLKS-1 the parser forces SYNC and pulses `o_Frame_Err`.
  - The counter is $clog2(TIMEOUT_CLKS) bits and saturates; it never wraps.
- Simultaneous events: a byte valid on the same cycle the timeout would fire wins. The byte is processed, the counter clears, and no error is raised.
- `o_Reg_WE` and `o_Frame_Err` are never high in the same cycle.

## Timing
- Reset values: `o_Reg_WE`=0, `o_Frame_Err`=0, `o_Busy`=0, `o_Reg_Addr`=0, `o_Reg_Data`=0. State = SYNC, counters and XOR = 0.
- Reset mid-frame abandons the frame immediately. No write and no error pulse are produced.
- All outputs are registered.
- Write latency: `o_Reg_WE` rises on the clock edge that samples `i_RX_DV`=1 with the CHK byte. It is visible the following cycle for exactly one cycle.
- Error latency is the same: one cycle after the CHK byte, or one cycle after the timeout condition is reached.
- `o_Busy` rises the cycle after the `0xA5` strobe and falls together with the WE/error pulse.
- Throughput: back-to-back frames are accepted with zero idle cycles. A `0xA5` strobe in the cycle after CHK is accepted.
- `i_RX_DV` pulses are at least CLKS_PER_BIT apart in practice, but the parser accepts a strobe on every cycle.

## Configuration
- `UART_CMD_ACK_EN` defined:
  - Adds output `o_Ack_DV` (1 bit) and output `o_Ack_Byte` (8 bits), intended to drive a UART transmitter.
  - `o_Ack_DV` pulses in the same cycle as `o_Reg_WE`, with `o_Ack_Byte`=`0x06`.
  - `o_Ack_DV` pulses in the same cycle as `o_Frame_Err`, with `o_Ack_Byte`=`0x15`.
  - Both reset to 0 and `o_Ack_Byte` holds between pulses.
- Not defined: both ports and their logic are absent; behaviour is otherwise identical.

## Test plan
- Valid frame A5 01 12 34 56 78 CHK=0x09 -> one `o_Reg_WE` pulse, Addr=0x01, Data=0x12345678, `o_Frame_Err` stays 0; with ACK, `0x06`.
- Same frame with CHK=0x08 -> no WE, one `o_Frame_Err` pulse one cycle after CHK; with ACK, `0x15`.
- ADDR=0x04 with correct CHK=0x0C and N_REGS=4 -> no WE, one error pulse.
- A5 02 AA, then no bytes for TIMEOUT_CLKS cycles -> error pulse, `o_Busy` falls. A following valid frame writes normally.
- Leading garbage 00 FF 5A, then a valid frame -> exactly one WE and no errors. A5 inside the payload (A5 00 A5 A5 A5 A5 CHK=0x00) -> Data=0xA5A5A5A5, Addr=0.
- Assert `i_Rst_L`=0 after D2 of a frame -> outputs go to reset values asynchronously. No WE or error pulse follows, and the next valid frame writes.
